// File: rtl/ov5640_dvp_pattern_tx_if.sv
// DVP video bus as driven by an OV5640-style source: frame sync, line valid
// and one pixel byte per clock.
interface ov5640_dvp_pattern_tx_if;
    logic       dvp_vsync;
    logic       dvp_href;
    logic [7:0] dvp_data;

    modport master (output dvp_vsync, output dvp_href, output dvp_data);
    modport slave  (input  dvp_vsync, input  dvp_href, input  dvp_data);
endinterface

// File: rtl/ov5640_dvp_pattern_tx.sv
// OV5640 DVP emulator: generates RGB565 test-pattern frames as vsync/href and
// two bytes per pixel (high byte first), so the capture path can run without
// a sensor. Every output is a flop; the output flops are loaded from the
// next-state counters so that they line up with the state they describe.
module ov5640_dvp_pattern_tx #(
    parameter int H_PIXEL     = 640,
    parameter int V_PIXEL     = 480,
    parameter int H_BLANK     = 160,
    parameter int VSYNC_LINES = 4,
    parameter int V_BACK      = 8,
    parameter int V_FRONT     = 4
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst_n,
    input  logic                           tx_en,
    input  logic [1:0]                     pattern_sel,
    input  logic [15:0]                    solid_rgb565,
    ov5640_dvp_pattern_tx_if.master        dvp,
    output logic                           frame_start,
    output logic                           frame_done,
    output logic [15:0]                    frame_cnt
);

    localparam int          LP        = 2 * H_PIXEL + H_BLANK;
    localparam logic [15:0] LP_LAST   = 16'(LP - 1);
    localparam logic [15:0] ACT_BYTES = 16'(2 * H_PIXEL);
    localparam logic [15:0] VS_LAST   = 16'(VSYNC_LINES - 1);
    localparam logic [15:0] VB_LAST   = 16'(V_BACK - 1);
    localparam logic [15:0] VP_LAST   = 16'(V_PIXEL - 1);
    localparam logic [15:0] VF_LAST   = 16'(V_FRONT - 1);
    localparam logic [10:0] BAR_LAST  = 11'(H_PIXEL / 8 - 1);
    localparam bit          HAS_VBACK = (V_BACK > 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_ACTIVE,
        S_VFRONT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] h_q, h_d;
    logic [15:0] v_q, v_d;
    logic [15:0] last_line;
    logic [10:0] bar_pos_q, bar_pos_d;
    logic [2:0]  bar_idx_q, bar_idx_d;
    logic [1:0]  sel_q;
    logic [15:0] solid_q;
    logic        vsync_q, href_q, start_q, done_q;
    logic [7:0]  data_q;
    logic [15:0] cnt_q;
    logic        start_d, done_d, href_d;
    logic [15:0] pix_d;
    logic [7:0]  data_d;

    // Frame sequencing: advance h every cycle, v every line, state every block of lines.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        start_d = 1'b0;

        case (state_q)
            S_VSYNC:  last_line = VS_LAST;
            S_VBACK:  last_line = VB_LAST;
            S_ACTIVE: last_line = VP_LAST;
            default:  last_line = VF_LAST;
        endcase

        if (state_q == S_IDLE) begin
            if (tx_en) begin
                state_d = S_VSYNC;
                h_d     = '0;
                v_d     = '0;
                start_d = 1'b1;
            end
        end else if (h_q != LP_LAST) begin
            h_d = h_q + 16'd1;
        end else begin
            h_d = '0;
            if (v_q != last_line) begin
                v_d = v_q + 16'd1;
            end else begin
                v_d = '0;
                case (state_q)
                    S_VSYNC:  state_d = HAS_VBACK ? S_VBACK : S_ACTIVE;
                    S_VBACK:  state_d = S_ACTIVE;
                    S_ACTIVE: state_d = S_VFRONT;
                    S_VFRONT: begin
                        // tx_en only matters here and in IDLE, so a mid-frame drop finishes the frame.
                        if (tx_en) begin
                            state_d = S_VSYNC;
                            start_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                    default:  state_d = S_IDLE;
                endcase
            end
        end

        done_d = (state_d == S_VFRONT) && (h_d == LP_LAST) && (v_d == VF_LAST);
    end

    // Colour-bar tracking without a divider: count pixels inside the current bar.
    always_comb begin
        bar_pos_d = bar_pos_q;
        bar_idx_d = bar_idx_q;
        if (h_d == 16'd0) begin
            bar_pos_d = '0;
            bar_idx_d = '0;
        end else if (!h_d[0] && (h_d < ACT_BYTES)) begin
            if (bar_pos_q == BAR_LAST) begin
                bar_pos_d = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_pos_d = bar_pos_q + 11'd1;
            end
        end
    end

    // Pixel for the upcoming cycle; x = h_d >> 1, so x[k] is h_d[k+1].
    always_comb begin
        pix_d = 16'h0000;
        case (sel_q)
            2'd0: begin
                case (bar_idx_d)
                    3'd0:    pix_d = 16'hFFFF;
                    3'd1:    pix_d = 16'hFFE0;
                    3'd2:    pix_d = 16'h07FF;
                    3'd3:    pix_d = 16'h07E0;
                    3'd4:    pix_d = 16'hF81F;
                    3'd5:    pix_d = 16'hF800;
                    3'd6:    pix_d = 16'h001F;
                    default: pix_d = 16'h0000;
                endcase
            end
            2'd1:    pix_d = {h_d[9:5], h_d[9:4], h_d[9:5]};
            2'd2:    pix_d = solid_q;
            default: pix_d = (h_d[6] ^ v_d[5] ^ cnt_q[0]) ? 16'hFFFF : 16'h0000;
        endcase

        href_d = (state_d == S_ACTIVE) && (h_d < ACT_BYTES);
        data_d = href_d ? (h_d[0] ? pix_d[7:0] : pix_d[15:8]) : 8'h00;
    end

    // State, counters, per-frame latched settings and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= S_IDLE;
            h_q       <= '0;
            v_q       <= '0;
            bar_pos_q <= '0;
            bar_idx_q <= '0;
            sel_q     <= '0;
            solid_q   <= '0;
            vsync_q   <= 1'b0;
            href_q    <= 1'b0;
            data_q    <= '0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q   <= state_d;
            h_q       <= h_d;
            v_q       <= v_d;
            bar_pos_q <= bar_pos_d;
            bar_idx_q <= bar_idx_d;
            if (start_d) begin
                sel_q   <= pattern_sel;
                solid_q <= solid_rgb565;
            end
            vsync_q   <= (state_d == S_VSYNC);
            href_q    <= href_d;
            data_q    <= data_d;
            start_q   <= start_d;
            done_q    <= done_d;
            if (done_d) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign dvp.dvp_vsync = vsync_q;
    assign dvp.dvp_href  = href_q;
    assign dvp.dvp_data  = data_q;
    assign frame_start   = start_q;
    assign frame_done    = done_q;
    assign frame_cnt     = cnt_q;

endmodule
